// File: rtl/rr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_pkg
// Description : Shared constants, FSM state encoding and one-hot helper for
//               the round-robin cell arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_arb_pkg;

  // Default build-time configuration
  localparam int c_DEF_N_REQ    = 4;
  localparam int c_DEF_MAX_HOLD = 8;

  // Arbiter FSM state encoding
  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_GRANT = 2'd1;
  localparam logic [1:0] c_ST_GAP   = 2'd2;

  // One-hot decode of an index into the widest supported requester vector
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    onehot8 = 8'b1 << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_pick
// Description : Combinational rotating priority encoder. Returns the first
//               active request at or after ptr, wrapping modulo N_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             pick_valid,
  output logic [ID_W-1:0]  pick_id
);

  // Choose the active requester with the smallest rotated distance from ptr
  always_comb begin
    int w_best;
    int w_dist;
    pick_valid = 1'b0;
    pick_id    = '0;
    w_best     = N_REQ;
    w_dist     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_dist = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + N_REQ - int'(ptr));
      if (req[i] && (w_dist < w_best)) begin
        w_best     = w_dist;
        pick_valid = 1'b1;
        pick_id    = ID_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_cell_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_cell_arbiter
// Description : Round-robin arbiter for one shared resource. Registered
//               one-hot grant, bounded hold time, one-cycle turnaround gap
//               between owners and a timeout pulse on forced preemption.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_cell_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N_REQ    = c_DEF_N_REQ,
  parameter int MAX_HOLD = c_DEF_MAX_HOLD,
  parameter int ID_W     = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_id,
  output logic             timeout_pulse,
  output logic             busy
);

  // Reject configurations the counter or index widths cannot represent
  generate
    if ((N_REQ < 2) || (N_REQ > 8) || (ID_W != $clog2(N_REQ)) ||
        (MAX_HOLD < 1) || (MAX_HOLD > 255) ||
        ((64'd1 << CNT_W) <= 64'(MAX_HOLD))) begin : g_param_error
      $error("rr_cell_arbiter: illegal N_REQ/MAX_HOLD/ID_W/CNT_W combination");
    end
  endgenerate

  logic [1:0]       r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [N_REQ-1:0] r_grant;
  logic             r_grant_valid;
  logic [ID_W-1:0]  r_grant_id;
  logic             r_timeout;

  logic             w_pick_valid;
  logic [ID_W-1:0]  w_pick_id;
  logic [N_REQ-1:0] w_pick_onehot;
  logic [ID_W-1:0]  w_next_ptr;
  logic             w_owner_req;
  logic             w_hold_done;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req        (req),
    .ptr        (r_ptr),
    .pick_valid (w_pick_valid),
    .pick_id    (w_pick_id)
  );

  // While in GRANT, r_grant_id is the owner; the pointer moves just past it
  assign w_pick_onehot = N_REQ'(onehot8(3'(w_pick_id)));
  assign w_next_ptr    = (r_grant_id == ID_W'(N_REQ - 1)) ? '0 : (r_grant_id + ID_W'(1));
  assign w_owner_req   = req[r_grant_id];
  assign w_hold_done   = (r_hold_cnt == CNT_W'(MAX_HOLD));

  // Arbitration FSM with hold counter and registered grant outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= c_ST_IDLE;
      r_ptr         <= '0;
      r_hold_cnt    <= '0;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_timeout     <= 1'b0;
    end else begin
      // The pulse lasts one cycle even when the tile is frozen
      r_timeout <= 1'b0;
      if (ena) begin
        case (r_state)
          c_ST_IDLE, c_ST_GAP: begin
            if (w_pick_valid) begin
              r_state       <= c_ST_GRANT;
              r_grant       <= w_pick_onehot;
              r_grant_valid <= 1'b1;
              r_grant_id    <= w_pick_id;
              r_hold_cnt    <= CNT_W'(1);
            end else begin
              r_state <= c_ST_IDLE;
            end
          end
          c_ST_GRANT: begin
            if (!w_owner_req || w_hold_done) begin
              // Release wins over timeout when both happen on the same edge
              r_timeout     <= w_owner_req;
              r_state       <= c_ST_GAP;
              r_ptr         <= w_next_ptr;
              r_grant       <= '0;
              r_grant_valid <= 1'b0;
              r_grant_id    <= '0;
              r_hold_cnt    <= '0;
            end else begin
              r_hold_cnt <= r_hold_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state <= c_ST_IDLE;
          end
        endcase
      end
    end
  end

  assign grant         = r_grant;
  assign grant_valid   = r_grant_valid;
  assign grant_id      = r_grant_id;
  assign timeout_pulse = r_timeout;
  assign busy          = (r_state == c_ST_GRANT) || (r_state == c_ST_GAP);

endmodule
`default_nettype wire

// File: tb/tb_rr_cell_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_cell_arbiter
// Description : Self-checking bench for rr_cell_arbiter (N_REQ=4, MAX_HOLD=4).
//               A cycle-level reference model is compared every cycle, and
//               directed scenarios pin literal expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_cell_arbiter;

  localparam int c_N  = 4;
  localparam int c_MH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       timeout_pulse;
  logic       busy;

  int checks = 0;
  int errors = 0;

  rr_cell_arbiter #(
    .N_REQ    (c_N),
    .MAX_HOLD (c_MH),
    .ID_W     (2),
    .CNT_W    (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .req           (req),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .grant_id      (grant_id),
    .timeout_pulse (timeout_pulse),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 = none), gap flag, pointer, hold length
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_gap   = 1'b0;
  bit m_to    = 1'b0;
  bit m_live  = 1'b0;

  always @(posedge clk) begin
    automatic int no = m_owner;
    automatic int np = m_ptr;
    automatic int nh = m_hold;
    automatic bit ng = m_gap;
    automatic bit nt = 1'b0;
    if (!rst_n) begin
      no = -1; np = 0; nh = 0; ng = 1'b0;
    end else if (ena) begin
      if (m_owner >= 0) begin
        if (!req[m_owner]) begin
          no = -1; ng = 1'b1; np = (m_owner + 1) % c_N;
        end else if (m_hold == c_MH) begin
          no = -1; ng = 1'b1; nt = 1'b1; np = (m_owner + 1) % c_N;
        end else begin
          nh = m_hold + 1;
        end
      end else begin
        ng = 1'b0;
        for (int k = 0; k < c_N; k++) begin
          if (req[(m_ptr + k) % c_N]) begin
            no = (m_ptr + k) % c_N;
            nh = 1;
            break;
          end
        end
      end
    end
    m_owner <= no;
    m_ptr   <= np;
    m_hold  <= nh;
    m_gap   <= ng;
    m_to    <= nt;
    if (!rst_n) m_live <= 1'b1;
  end

  // Compare DUT against the model on every falling edge once reset was seen
  always @(negedge clk) begin
    logic [3:0] eg;
    logic [1:0] eid;
    if (m_live) begin
      eg  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      eid = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
      chk("model_grant", grant, eg);
      chk("model_grant_valid", grant_valid, m_owner >= 0);
      chk("model_grant_id", grant_id, eid);
      chk("model_timeout", timeout_pulse, m_to);
      chk("model_busy", busy, (m_owner >= 0) || m_gap);
    end
  end

  logic [3:0] sat_exp [21] = '{
    4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
    4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
    4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000,
    4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000,
    4'b0001
  };

  initial begin
    // Reset held with all requests active
    rst_n = 1'b0; ena = 1'b1; req = 4'b1111;
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    // Saturation: every owner times out after MAX_HOLD cycles
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      chk("sat_grant", grant, sat_exp[i]);
      chk("sat_timeout", timeout_pulse, sat_exp[i] == 4'b0000);
      if (i == 0) chk("first_grant_id", grant_id, 2'd0);
    end

    // Skip idle requesters: ptr=1, req=1001 -> owner 3, then wrap to 0
    req = 4'b0000;
    @(negedge clk);
    chk("skip_gap_busy", busy, 1'b1);
    chk("skip_gap_timeout", timeout_pulse, 1'b0);
    req = 4'b1001;
    @(negedge clk);
    chk("skip_grant3", grant, 4'b1000);
    chk("skip_grant3_id", grant_id, 2'd3);
    req = 4'b0001;
    @(negedge clk);
    chk("skip_gap2", grant, 4'b0000);
    @(negedge clk);
    chk("skip_grant0", grant, 4'b0001);

    // Single requester: three grant cycles, one gap, then idle
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    chk("single_idle_busy", busy, 1'b0);
    req = 4'b0100;
    repeat (3) begin
      @(negedge clk);
      chk("single_grant", grant, 4'b0100);
    end
    req = 4'b0000;
    @(negedge clk);
    chk("single_gap_grant", grant, 4'b0000);
    chk("single_gap_busy", busy, 1'b1);
    @(negedge clk);
    chk("single_idle", busy, 1'b0);
    req = 4'b1111;
    @(negedge clk);
    chk("single_next_ptr3", grant, 4'b1000);

    // Enable freeze with owner 2 at hold count 2
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    chk("freeze_pre", grant, 4'b0100);
    ena = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("freeze_hold", grant, 4'b0100);
    end
    ena = 1'b1;
    @(negedge clk);
    chk("freeze_run1", grant, 4'b0100);
    @(negedge clk);
    chk("freeze_run2", grant, 4'b0100);
    @(negedge clk);
    chk("freeze_to_grant", grant, 4'b0000);
    chk("freeze_to_pulse", timeout_pulse, 1'b1);
    ena = 1'b0;
    @(negedge clk);
    chk("freeze_pulse_clear", timeout_pulse, 1'b0);
    chk("freeze_gap_busy", busy, 1'b1);
    ena = 1'b1;
    @(negedge clk);
    chk("freeze_rejoin", grant, 4'b0100);

    // Reset while owner 1 holds the grant
    req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_pre", grant, 4'b0010);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_grant", grant, 4'b0000);
    chk("midrst_busy", busy, 1'b0);
    req = 4'b0011;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ptr0", grant, 4'b0001);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
